// File: rtl/execute_pkg.sv
// Shared types and helpers for the execute stage.
package execute_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_NOR   = 5'd5,
        ALU_SLT   = 5'd6,
        ALU_SLTU  = 5'd7,
        ALU_SLL   = 5'd8,
        ALU_SRL   = 5'd9,
        ALU_SRA   = 5'd10,
        ALU_LUI   = 5'd11,
        ALU_MULT  = 5'd12,
        ALU_MULTU = 5'd13,
        ALU_DIV   = 5'd14,
        ALU_DIVU  = 5'd15,
        ALU_MFHI  = 5'd16,
        ALU_MFLO  = 5'd17,
        ALU_MTHI  = 5'd18,
        ALU_MTLO  = 5'd19
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FIX
    } muldiv_state_e;

    localparam int unsigned MULDIV_ITER = 32;

    // True for any operation that reads or writes HI/LO or starts mult/div.
    function automatic logic is_hilo_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV)  ||
               (op == ALU_DIVU) || (op == ALU_MFHI)  || (op == ALU_MFLO) ||
               (op == ALU_MTHI) || (op == ALU_MTLO);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative 32-bit multiply/divide: one shift-add or restoring
// shift-subtract step per cycle, then a sign-fix cycle.
module execute_muldiv
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
);

    muldiv_state_e state, state_n;
    logic [5:0]    cnt;
    logic [31:0]   r;
    logic [31:0]   q;
    logic [31:0]   opa;
    logic          div_op;
    logic          q_neg;
    logic          r_neg;

    logic [32:0]   add_sum;
    logic [33:0]   sub_diff;
    logic [31:0]   a_abs;
    logic [31:0]   b_abs;
    logic          a_neg;
    logic          b_neg;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state: IDLE -> BUSY on start, BUSY for MULDIV_ITER steps, FIX for one cycle.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start) state_n = ST_BUSY;
            ST_BUSY: if (cnt == 6'(MULDIV_ITER - 1)) state_n = ST_FIX;
            ST_FIX:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand magnitudes and per-step arithmetic.
    always_comb begin
        a_neg    = is_signed & a[31];
        b_neg    = is_signed & b[31];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        add_sum  = {1'b0, r} + (q[0] ? {1'b0, opa} : 33'd0);
        sub_diff = {1'b0, r, q[31]} - {2'b00, opa};
    end

    // Datapath: q holds multiplier/dividend and shifts in product/quotient bits; r is the upper half/remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            r      <= '0;
            q      <= '0;
            opa    <= '0;
            div_op <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        r      <= '0;
                        q      <= a_abs;
                        opa    <= b_abs;
                        div_op <= is_div;
                        // Divide by zero keeps the all-ones quotient unsigned.
                        q_neg  <= (a_neg ^ b_neg) & ~(is_div & (b == 32'd0));
                        r_neg  <= is_div & a_neg;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt + 6'd1;
                    if (div_op) begin
                        if (!sub_diff[33]) begin
                            r <= sub_diff[31:0];
                            q <= {q[30:0], 1'b1};
                        end else begin
                            r <= {r[30:0], q[31]};
                            q <= {q[30:0], 1'b0};
                        end
                    end else begin
                        r <= add_sum[32:1];
                        q <= {add_sum[0], q[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sign-corrected result, valid while done is high.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_FIX);
        if (div_op)
            result = {(r_neg ? -r : r), (q_neg ? -q : q)};
        else
            result = q_neg ? -{r, q} : {r, q};
    end

endmodule

// File: rtl/execute.sv
// MIPS execute stage: single-cycle ALU, HI/LO registers, stall for
// HI/LO hazards against the iterative mult/div, and ex->mem registers.
module execute
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int REGS_DEPTH  = 5,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     reg_s_data_ex,
    input  logic [DATA_WIDTH-1:0]     reg_t_data_ex,
    input  logic [DATA_WIDTH-1:0]     imm_ex,
    input  logic [SHAMT_WIDTH-1:0]    shamt_ex,
    input  logic [4:0]                alu_op_ex,
    input  logic                      alu_src_sel_ex,
    input  logic                      reg_d_we_ex,
    input  logic [REGS_DEPTH-1:0]     reg_d_addr_ex,
    input  logic                      reg_d_data_sel_ex,
    input  logic [DATA_WIDTH/8-1:0]   mem_we_ex,
    output logic                      stall_ex,
    output logic [DATA_WIDTH-1:0]     alu_data_mem,
    output logic [DATA_WIDTH-1:0]     reg_t_data_mem,
    output logic                      reg_d_we_mem,
    output logic [REGS_DEPTH-1:0]     reg_d_addr_mem,
    output logic                      reg_d_data_sel_mem,
    output logic [DATA_WIDTH/8-1:0]   mem_we_mem
);

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  md_start;
    logic                  md_signed;
    logic                  md_div;
    logic                  md_busy;
    logic                  md_done;
    logic [63:0]           md_result;

    // Operand selection, mult/div decode and hazard stall.
    always_comb begin
        op_a      = reg_s_data_ex;
        op_b      = alu_src_sel_ex ? imm_ex : reg_t_data_ex;
        md_start  = (alu_op_ex == ALU_MULT) || (alu_op_ex == ALU_MULTU) ||
                    (alu_op_ex == ALU_DIV)  || (alu_op_ex == ALU_DIVU);
        md_signed = (alu_op_ex == ALU_MULT) || (alu_op_ex == ALU_DIV);
        md_div    = (alu_op_ex == ALU_DIV)  || (alu_op_ex == ALU_DIVU);
        stall_ex  = md_busy && is_hilo_op(alu_op_ex);
    end

    // Single-cycle ALU.
    always_comb begin
        alu_res = '0;
        case (alu_op_ex)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_NOR:  alu_res = ~(op_a | op_b);
            ALU_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? DATA_WIDTH'(1) : '0;
            ALU_SLTU: alu_res = (op_a < op_b) ? DATA_WIDTH'(1) : '0;
            ALU_SLL:  alu_res = op_b << shamt_ex;
            ALU_SRL:  alu_res = op_b >> shamt_ex;
            ALU_SRA:  alu_res = $unsigned($signed(op_b) >>> shamt_ex);
            ALU_LUI:  alu_res = {op_b[15:0], {(DATA_WIDTH-16){1'b0}}};
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = '0;
        endcase
    end

    // The unit only sees start while idle, so it never restarts mid-operation.
    execute_muldiv u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start && !md_busy),
        .is_signed (md_signed),
        .is_div    (md_div),
        .a         (op_a),
        .b         (op_b),
        .busy      (md_busy),
        .done      (md_done),
        .result    (md_result)
    );

    // HI/LO: mult/div completion or MTHI/MTLO (the two are mutually exclusive in time).
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (md_done) begin
            hi <= md_result[63:32];
            lo <= md_result[31:0];
        end else if (!stall_ex) begin
            if (alu_op_ex == ALU_MTHI) hi <= op_a;
            if (alu_op_ex == ALU_MTLO) lo <= op_a;
        end
    end

    // ex->mem pipeline register; a stalled instruction becomes a bubble.
    always_ff @(posedge clk) begin
        if (rst || stall_ex) begin
            alu_data_mem       <= '0;
            reg_t_data_mem     <= '0;
            reg_d_we_mem       <= 1'b0;
            reg_d_addr_mem     <= '0;
            reg_d_data_sel_mem <= 1'b0;
            mem_we_mem         <= '0;
        end else begin
            alu_data_mem       <= alu_res;
            reg_t_data_mem     <= reg_t_data_ex;
            reg_d_we_mem       <= reg_d_we_ex;
            reg_d_addr_mem     <= reg_d_addr_ex;
            reg_d_data_sel_mem <= reg_d_data_sel_ex;
            mem_we_mem         <= mem_we_ex;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage.
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_s_data_ex;
    logic [31:0] reg_t_data_ex;
    logic [31:0] imm_ex;
    logic [4:0]  shamt_ex;
    logic [4:0]  alu_op_ex;
    logic        alu_src_sel_ex;
    logic        reg_d_we_ex;
    logic [4:0]  reg_d_addr_ex;
    logic        reg_d_data_sel_ex;
    logic [3:0]  mem_we_ex;
    logic        stall_ex;
    logic [31:0] alu_data_mem;
    logic [31:0] reg_t_data_mem;
    logic        reg_d_we_mem;
    logic [4:0]  reg_d_addr_mem;
    logic        reg_d_data_sel_mem;
    logic [3:0]  mem_we_mem;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_stall;

    execute #(.DATA_WIDTH(32), .REGS_DEPTH(5), .SHAMT_WIDTH(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .reg_s_data_ex      (reg_s_data_ex),
        .reg_t_data_ex      (reg_t_data_ex),
        .imm_ex             (imm_ex),
        .shamt_ex           (shamt_ex),
        .alu_op_ex          (alu_op_ex),
        .alu_src_sel_ex     (alu_src_sel_ex),
        .reg_d_we_ex        (reg_d_we_ex),
        .reg_d_addr_ex      (reg_d_addr_ex),
        .reg_d_data_sel_ex  (reg_d_data_sel_ex),
        .mem_we_ex          (mem_we_ex),
        .stall_ex           (stall_ex),
        .alu_data_mem       (alu_data_mem),
        .reg_t_data_mem     (reg_t_data_mem),
        .reg_d_we_mem       (reg_d_we_mem),
        .reg_d_addr_mem     (reg_d_addr_mem),
        .reg_d_data_sel_mem (reg_d_data_sel_mem),
        .mem_we_mem         (mem_we_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] t,
                         input logic [31:0] imm, input logic sel, input logic [4:0] sh,
                         input logic we, input logic [4:0] addr);
        alu_op_ex      = op;
        reg_s_data_ex  = a;
        reg_t_data_ex  = t;
        imm_ex         = imm;
        alu_src_sel_ex = sel;
        shamt_ex       = sh;
        reg_d_we_ex    = we;
        reg_d_addr_ex  = addr;
        #1;
    endtask

    // Present an instruction, wait out any stall (bounded), and let it be accepted.
    task automatic issue_wait(input string tag, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] t, output int unsigned n);
        drive(op, a, t, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        n = 0;
        while (stall_ex && n < 100) begin
            step();
            n++;
        end
        if (n != 0) check({tag, "_bubble"}, {31'd0, reg_d_we_mem, alu_data_mem}, 64'd0);
        check({tag, "_released"}, {63'd0, stall_ex}, 64'd0);
        step();
    endtask

    task automatic read_hilo(input string tag, input logic [4:0] op, input logic [31:0] exp);
        int unsigned n;
        issue_wait(tag, op, 32'd0, 32'd0, n);
        check(tag, {32'd0, alu_data_mem}, {32'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        reg_d_data_sel_ex = 1'b1;
        mem_we_ex = 4'hF;
        drive(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 1'b1, 5'd5);
        step();
        step();
        check("reset_mem", {reg_d_we_mem, reg_d_addr_mem, reg_d_data_sel_mem, mem_we_mem, alu_data_mem},
              64'd0);
        check("reset_stall", {63'd0, stall_ex}, 64'd0);
        rst = 1'b0;
        reg_d_data_sel_ex = 1'b0;
        mem_we_ex = 4'h0;

        drive(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        step();
        check("add", {32'd0, alu_data_mem}, 64'hC);
        check("add_pass", {reg_t_data_mem, 26'd0, reg_d_we_mem, reg_d_addr_mem}, {32'd7, 26'd0, 1'b1, 5'd3});

        drive(ALU_SUB, 32'd5, 32'd99, 32'd7, 1'b1, 5'd0, 1'b1, 5'd4);
        step();
        check("sub_imm", {32'd0, alu_data_mem}, 64'hFFFFFFFE);
        check("sub_tdata", {32'd0, reg_t_data_mem}, 64'd99);

        drive(ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1, 5'd1);
        step();
        check("slt", {32'd0, alu_data_mem}, 64'd1);
        drive(ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 1'b1, 5'd1);
        step();
        check("sltu", {32'd0, alu_data_mem}, 64'd0);
        drive(ALU_SRA, 32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 1'b1, 5'd1);
        step();
        check("sra", {32'd0, alu_data_mem}, 64'hF8000000);
        drive(ALU_SRL, 32'd0, 32'h80000000, 32'd0, 1'b0, 5'd4, 1'b1, 5'd1);
        step();
        check("srl", {32'd0, alu_data_mem}, 64'h08000000);
        drive(ALU_LUI, 32'd0, 32'd0, 32'h00001234, 1'b1, 5'd0, 1'b1, 5'd1);
        step();
        check("lui", {32'd0, alu_data_mem}, 64'h12340000);
        drive(ALU_NOR, 32'hF0F0F0F0, 32'h0000FFFF, 32'd0, 1'b0, 5'd0, 1'b1, 5'd1);
        step();
        check("nor", {32'd0, alu_data_mem}, 64'h0F0F0000);

        mem_we_ex = 4'hA;
        drive(5'd31, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0, 1'b1, 5'd2);
        step();
        check("undef_op", {28'd0, mem_we_mem, alu_data_mem}, {28'd0, 4'hA, 32'd0});
        mem_we_ex = 4'h0;

        // MULT -3 x 4 followed immediately by MFLO: 33 stalled cycles.
        drive(ALU_MULT, 32'hFFFFFFFD, 32'd4, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        issue_wait("mflo_mult", ALU_MFLO, 32'd0, 32'd0, n_stall);
        check("mult_stall_cycles", {32'd0, n_stall}, 64'd33);
        check("mult_lo", {32'd0, alu_data_mem}, 64'hFFFFFFF4);
        read_hilo("mult_hi", ALU_MFHI, 32'hFFFFFFFF);

        drive(ALU_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        read_hilo("div_lo", ALU_MFLO, 32'hFFFFFFFD);
        read_hilo("div_hi", ALU_MFHI, 32'hFFFFFFFF);

        drive(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        read_hilo("divovf_lo", ALU_MFLO, 32'h80000000);
        read_hilo("divovf_hi", ALU_MFHI, 32'h00000000);

        // Independent ADD runs during BUSY; a second MULT waits.
        drive(ALU_MULTU, 32'd3, 32'd5, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(ALU_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        check("add_busy_nostall", {63'd0, stall_ex}, 64'd0);
        step();
        check("add_busy", {32'd0, alu_data_mem}, 64'd30);
        issue_wait("mult2", ALU_MULT, 32'd6, 32'd7, n_stall);
        check("mult2_stall_cycles", {32'd0, n_stall}, 64'd32);
        read_hilo("mult2_lo", ALU_MFLO, 32'd42);

        drive(ALU_DIVU, 32'd7, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        read_hilo("div0_lo", ALU_MFLO, 32'hFFFFFFFF);
        read_hilo("div0_hi", ALU_MFHI, 32'd7);

        // Reset during iteration 10 of a DIV aborts it.
        drive(ALU_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        for (int i = 0; i < 10; i++) step();
        check("div_midway_stall", {63'd0, stall_ex}, 64'd1);
        rst = 1'b1;
        step();
        check("rst_abort_stall", {63'd0, stall_ex}, 64'd0);
        check("rst_abort_mem", {reg_t_data_mem, alu_data_mem}, 64'd0);
        check("rst_abort_ctl", {52'd0, reg_d_we_mem, reg_d_addr_mem, reg_d_data_sel_mem, mem_we_mem}, 64'd0);
        rst = 1'b0;
        drive(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 40; i++) step();
        read_hilo("rst_lo", ALU_MFLO, 32'd0);
        read_hilo("rst_hi", ALU_MFHI, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
